// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result stage.
//   DATA_W_DEF  default ALU result width
//   FLAGS_W     width of the ALU flag vector {sign,carry,zero,overflow,parity}
//   SIGN..PARITY bit positions inside the flag vector
//   occ_t       occupancy encoding of the 2-entry result FIFO
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FLAGS_W    = 5;

  localparam int SIGN   = 4;
  localparam int CARRY  = 3;
  localparam int ZERO   = 2;
  localparam int OVF    = 1;
  localparam int PARITY = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: 2-entry in-order buffer with valid/ready handshakes.
// The head entry always lives in head_q so data_out is a plain register
// output and stays stable while the consumer stalls.
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready producer handshake; in_ready depends on occupancy only
//   data_in           entry to buffer
//   out_valid/out_ready consumer handshake
//   data_out          head entry
//
// state | meaning
// EMPTY | no entries buffered
// ONE   | head_q valid
// TWO   | head_q and tail_q valid, producer stalled
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int W = DATA_W_DEF + FLAGS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out
);

  occ_t         state, state_nxt;
  logic [W-1:0] head_q, tail_q;
  logic         push, pop;

  // Held low during reset so nothing is accepted while the buffer is cleared.
  assign in_ready  = (state != TWO) && !rst;
  assign out_valid = (state == ONE) || (state == TWO);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign data_out  = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = TWO;
        else if (pop && !push) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head_q <= data_in;
        ONE: begin
          // Simultaneous push+pop replaces the head directly.
          if (push && pop) head_q <= data_in;
          else if (push)   tail_q <= data_in;
        end
        TWO:     if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results with their flags, tracks the flags
// of the last consumed entry and counts consumed entries.
// Optional feature: define ALU_STICKY_OVF_EN to build the sticky overflow
// indicator; otherwise sticky_ovf is tied low and clr_sticky is ignored.
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     producer handshake
//   v_in, flags_in        ALU result and {sign,carry,zero,overflow,parity}
//   out_valid/out_ready   consumer handshake
//   v_out, flags_out      head entry
//   status                flags of the most recently consumed entry
//   clr_sticky/sticky_ovf sticky overflow clear / indicator
//   xfer_cnt              wrapping count of consumed entries
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] v_in,
  input  logic [4:0]        flags_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] v_out,
  output logic [4:0]        flags_out,
  output logic [4:0]        status,
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic [15:0]       xfer_cnt
);

  localparam int ENT_W = DATA_W + FLAGS_W;

  logic [ENT_W-1:0] head;
  logic             pop;

  alu_result_fifo #(.W(ENT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   ({v_in, flags_in}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (head)
  );

  assign v_out     = head[ENT_W-1:FLAGS_W];
  assign flags_out = head[FLAGS_W-1:0];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status   <= '0;
      xfer_cnt <= '0;
    end else if (pop) begin
      status   <= flags_out;
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  // Set wins over clear so an overflow popped in the clearing cycle is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       sticky_ovf <= 1'b0;
    else if (pop && flags_out[OVF]) sticky_ovf <= 1'b1;
    else if (clr_sticky)           sticky_ovf <= 1'b0;
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, ALU result width.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port in_valid  input  1  ALU result and flags valid this cycle.
REQ-005 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-006 SHALL have port v_in  input  DATA_W  ALU result V.
REQ-007 SHALL have port flags_in  input  5  {sign,carry,zero,overflow,parity} from ALU.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port v_out  output  DATA_W  head result.
REQ-011 SHALL have port flags_out  output  5  head flags, same bit order as flags_in.
REQ-012 SHALL have port status  output  5  flags of the most recently consumed entry.
REQ-013 SHALL have port clr_sticky  input  1  clears sticky_ovf (when compiled in).
REQ-014 SHALL have port sticky_ovf  output  1  sticky overflow indicator (when compiled in).
REQ-015 SHALL have port xfer_cnt  output  16  count of consumed entries.

Function
REQ-016 SHALL buffer entries {v_in,flags_in} in a 2-entry in-order FIFO with occupancy states EMPTY, ONE, TWO.
REQ-017 SHALL push when in_valid && in_ready, and pop when out_valid && out_ready, both on the clk edge.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO; in_ready SHALL depend on state only, not on out_ready.
REQ-019 SHALL drive out_valid = 1 in ONE and TWO.
REQ-020 Transitions SHALL be: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; otherwise hold.
REQ-021 Latency SHALL be one cycle: entry pushed at edge N is presented on v_out/flags_out with out_valid after edge N when the FIFO was EMPTY.
REQ-022 v_out/flags_out SHALL hold stable while out_valid && !out_ready.
REQ-023 Entries SHALL pop in push order; no entry SHALL be dropped or duplicated.
REQ-024 On pop, status SHALL load the popped flags and xfer_cnt SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-025 Flags SHALL pass through unmodified; this stage SHALL NOT recompute them from V.

Reset
REQ-026 Asserting rst SHALL immediately force state EMPTY, in_ready=0 while rst high, out_valid=0, v_out=0, flags_out=0, status=0, xfer_cnt=0, sticky_ovf=0.
REQ-027 After rst deasserts, in_ready SHALL be 1 from the first cycle; entries buffered before a mid-operation reset SHALL be discarded.

Configuration
REQ-028 With macro ALU_STICKY_OVF_EN defined, sticky_ovf SHALL set on pop of an entry whose overflow flag is 1, and clear on clr_sticky; simultaneous set and clear SHALL leave it set.
REQ-029 Without ALU_STICKY_OVF_EN, sticky_ovf SHALL be tied 0 and clr_sticky ignored.

Structure
REQ-030 A shared package alu_pkg SHALL hold DATA_W default, flag bit-index constants (SIGN=4,CARRY=3,ZERO=2,OVF=1,PARITY=0) and the occupancy state encoding.
REQ-031 Storage and occupancy SHALL be a sub-module alu_result_fifo; status, counter and sticky logic SHALL live in alu_result_stage.

Verification
REQ-032 Reset then push v_in=16'h8FFF, flags_in=5'b10000, out_ready=1 -> next cycle out_valid=1, v_out=16'h8FFF, flags_out=5'b10000; after pop status=5'b10000, xfer_cnt=1.
REQ-033 out_ready=0, push 16'h0000/5'b01100 then 16'hFFFF/5'b10001 -> state TWO, in_ready=0, v_out holds 16'h0000; then out_ready=1 -> pops 16'h0000 then 16'hFFFF in order.
REQ-034 In ONE, push and pop same cycle -> state stays ONE, out_valid stays 1, xfer_cnt+1, no loss.
REQ-035 With ALU_STICKY_OVF_EN, pop entry flags 5'b00010 while clr_sticky=1 -> sticky_ovf=1; next cycle clr_sticky=1, no pop -> sticky_ovf=0; without macro sticky_ovf stays 0.
REQ-036 Assert rst in TWO mid-stream -> out_valid=0, xfer_cnt=0 immediately (before next clk edge); 65536 pops from xfer_cnt=0 -> xfer_cnt=0.
